// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_display
// Purpose  : Double-buffered hex scanner for a multiplexed 7-segment array,
//            fed over valid/ready, with a live busy flag on digit 0's dp.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_display #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 16,
    parameter int ACTIVE_LOW   = 1,
    parameter int BLANK_LZ     = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  busy,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                DATA_W   = 4 * DIGITS;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic              INV      = (ACTIVE_LOW != 0);
    localparam logic              BLANK_EN = (BLANK_LZ != 0);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_W-1:0]       disp_q, disp_d;
    logic [DATA_W-1:0]       pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic                    in_ready_q, in_ready_d;
    logic [DIGITS-1:0]       an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    tick;
    logic                    frame_end;
    logic                    xfer;
    logic [DIGITS-1:0]       lz_blank;
    logic [DIGITS-1:0]       an_act;
    logic [3:0]              nib;
    logic                    digit_blank;
    logic [6:0]              code;

    // A digit above 0 is blank when it and every more-significant nibble are zero.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_blank
            if (k == 0) begin : g_first
                assign lz_blank[k] = 1'b0;
            end else begin : g_upper
                assign lz_blank[k] = BLANK_EN && (disp_q[DATA_W-1:4*k] == '0);
            end
        end
    endgenerate

    always_comb begin
        cnt_d       = cnt_q + REFRESH_BITS'(1);
        tick        = &cnt_q;
        frame_end   = tick && (idx_q == IDX_LAST);
        idx_d       = idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        xfer        = in_valid && in_ready_q;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        // A word accepted on the boundary itself waits for the next frame.
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
        end
        in_ready_d = !pend_full_d;
    end

    always_comb begin
        nib         = '0;
        an_act      = '0;
        digit_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib         = disp_q[4*k +: 4];
                an_act[k]   = 1'b1;
                digit_blank = lz_blank[k];
            end
        end
        code  = digit_blank ? 7'h00 : hex_to_seg(nib);
        an_d  = an_act ^ {DIGITS{INV}};
        seg_d = code ^ {7{INV}};
        dp_d  = ((idx_q == '0) && busy) ^ INV;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
            an_q        <= {DIGITS{INV}};
            seg_q       <= {7{INV}};
            dp_q        <= INV;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            in_ready_q  <= in_ready_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign in_ready = in_ready_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule
`default_nettype wire
